mac_test_ctrl: RTL and testbench

- Sequencer for the DDR bandwidth-test accumulator path.
- On a start pulse it:
  - clears the accumulator;
  - opens the read stream for exactly LEN beats and counts the accepted beats;
  - waits for the accumulator pipeline to drain;
  - emits the final sum as a single AXIS beat toward the writer.
- Also measures the number of read cycles for bandwidth calculation and aborts on a stalled stream.

---
 rtl/mac_test_ctrl.sv | 120 ++++++++++++
 tb/tb_mac_test_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mac_test_ctrl.sv
// Sequencer for the DDR bandwidth-test accumulator path: clear, read LEN beats,
// drain the accumulator pipeline, emit the sum as one AXIS beat, report counts.
module mac_test_ctrl #(
    parameter int DATA_WIDTH = 64,
    parameter int LEN_W      = 32,
    parameter int ACC_LAT    = 2,
    parameter int TIMEOUT    = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [LEN_W-1:0]      len,
    output logic                  acc_clr,
    input  logic                  rd_tvalid,
    output logic                  rd_tready,
    input  logic [DATA_WIDTH-1:0] acc_sum,
    output logic                  m_axis_tvalid,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    input  logic                  m_axis_tready,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [LEN_W-1:0]      beats,
    output logic [LEN_W-1:0]      cycles
);

    typedef enum logic [2:0] {IDLE, CLEAR, READ, DRAIN, WRITE, DONE} state_t;

    // ACC_LAT and TIMEOUT are both expected to be at least 1.
    localparam logic [LEN_W-1:0] TIMEOUT_M1 = LEN_W'(TIMEOUT - 1);
    localparam logic [LEN_W-1:0] DRAIN_LAST = LEN_W'(ACC_LAT - 1);
    localparam logic [LEN_W-1:0] ONE        = LEN_W'(1);

    state_t           state;
    state_t           state_nx;
    logic [LEN_W-1:0] len_r;
    logic [LEN_W-1:0] beat_cnt;
    logic [LEN_W-1:0] cycle_cnt;
    logic [LEN_W-1:0] idle_cnt;
    logic [LEN_W-1:0] drain_cnt;
    logic             rd_hs;
    logic             last_beat;
    logic             stalled;

    assign acc_clr       = (state == CLEAR);
    assign rd_tready     = (state == READ);
    assign m_axis_tvalid = (state == WRITE);
    assign busy          = (state != IDLE);
    assign done          = (state == DONE);

    assign rd_hs     = rd_tvalid && (state == READ);
    assign last_beat = rd_hs && ((beat_cnt + ONE) == len_r);
    assign stalled   = !rd_hs && (state == READ) && (idle_cnt == TIMEOUT_M1);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = CLEAR;
            CLEAR:   state_nx = (len_r != '0) ? READ : DRAIN;
            READ: begin
                if (last_beat)    state_nx = DRAIN;
                else if (stalled) state_nx = DONE;
            end
            DRAIN:   if (drain_cnt == DRAIN_LAST) state_nx = WRITE;
            WRITE:   if (m_axis_tready) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Reported beats/cycles only change when a test finishes, so an aborted
    // run (via rst) never exposes partial counts.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            len_r        <= '0;
            beat_cnt     <= '0;
            cycle_cnt    <= '0;
            idle_cnt     <= '0;
            drain_cnt    <= '0;
            err          <= 1'b0;
            m_axis_tdata <= '0;
            beats        <= '0;
            cycles       <= '0;
        end else begin
            state     <= state_nx;
            drain_cnt <= (state == DRAIN) ? drain_cnt + ONE : '0;
            case (state)
                IDLE: begin
                    if (start) begin
                        len_r     <= len;
                        err       <= 1'b0;
                        beat_cnt  <= '0;
                        cycle_cnt <= '0;
                        idle_cnt  <= '0;
                    end
                end
                READ: begin
                    if (cycle_cnt != '1) cycle_cnt <= cycle_cnt + ONE;
                    if (rd_hs) begin
                        beat_cnt <= beat_cnt + ONE;
                        idle_cnt <= '0;
                    end else begin
                        idle_cnt <= idle_cnt + ONE;
                    end
                    if (stalled) err <= 1'b1;
                end
                DRAIN: begin
                    if (drain_cnt == DRAIN_LAST) m_axis_tdata <= acc_sum;
                end
                DONE: begin
                    beats  <= beat_cnt;
                    cycles <= cycle_cnt;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_test_ctrl.sv
// Directed bench for mac_test_ctrl: a per-test timeline model predicts every
// output each cycle; a negedge process compares the DUT against it.
module tb_mac_test_ctrl;

    localparam int DATA_WIDTH = 64;
    localparam int LEN_W      = 32;
    localparam int ACC_LAT    = 2;
    localparam int TIMEOUT    = 8;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  start;
    logic [LEN_W-1:0]      len;
    logic                  acc_clr;
    logic                  rd_tvalid;
    logic                  rd_tready;
    logic [DATA_WIDTH-1:0] acc_sum;
    logic                  m_axis_tvalid;
    logic [DATA_WIDTH-1:0] m_axis_tdata;
    logic                  m_axis_tready;
    logic                  busy;
    logic                  done;
    logic                  err;
    logic [LEN_W-1:0]      beats;
    logic [LEN_W-1:0]      cycles;

    mac_test_ctrl #(
        .DATA_WIDTH(DATA_WIDTH),
        .LEN_W     (LEN_W),
        .ACC_LAT   (ACC_LAT),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .len          (len),
        .acc_clr      (acc_clr),
        .rd_tvalid    (rd_tvalid),
        .rd_tready    (rd_tready),
        .acc_sum      (acc_sum),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tready(m_axis_tready),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .beats        (beats),
        .cycles       (cycles)
    );

    always #5 clk = ~clk;

    int   checks     = 0;
    int   failures   = 0;
    int   done_count = 0;
    int   hs_count   = 0;
    logic chk_en     = 1'b0;

    logic                  exp_acc_clr, exp_rd_tready, exp_tvalid, exp_busy, exp_done, exp_err;
    logic [DATA_WIDTH-1:0] exp_tdata;
    logic [LEN_W-1:0]      exp_beats, exp_cycles;

    // Results the model believes the DUT is currently holding between tests.
    logic [DATA_WIDTH-1:0] m_tdata;
    logic                  m_err;
    logic [LEN_W-1:0]      m_beats, m_cycles;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h", name, act, expv);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            checkOutput("acc_clr",   64'(acc_clr),       64'(exp_acc_clr));
            checkOutput("rd_tready", 64'(rd_tready),     64'(exp_rd_tready));
            checkOutput("tvalid",    64'(m_axis_tvalid), 64'(exp_tvalid));
            checkOutput("tdata",     m_axis_tdata,       exp_tdata);
            checkOutput("busy",      64'(busy),          64'(exp_busy));
            checkOutput("done",      64'(done),          64'(exp_done));
            checkOutput("err",       64'(err),           64'(exp_err));
            checkOutput("beats",     64'(beats),         64'(exp_beats));
            checkOutput("cycles",    64'(cycles),        64'(exp_cycles));
            if (m_axis_tvalid && m_axis_tready) hs_count++;
            if (done) done_count++;
        end
    end

    // One test: start in cycle 0, CLEAR in cycle 1, READ from cycle 2.
    // pat[i] is rd_tvalid in the i-th READ cycle; hold is the number of WRITE
    // cycles with tready low; acc_sum(k) = step * min(k, cap); rst_at > 0
    // pulses rst in that cycle.
    task automatic applyStimulus(input logic [LEN_W-1:0] t_len, input logic [31:0] pat,
                                 input int hold, input logic [63:0] step, input int cap,
                                 input bit start_in_read, input bit start_in_done,
                                 input int rst_at);
        int                    n, b, idle, wstart, done_k, last_k, cc, exp_dc, exp_hs;
        bit                    abort, was_reset;
        logic [DATA_WIDTH-1:0] cap_val;
        n = 0; b = 0; idle = 0; abort = 1'b0;
        if (t_len != '0) begin
            for (int i = 0; i < 64; i++) begin
                n = i + 1;
                if (i < 32 && pat[i]) begin
                    b++;
                    idle = 0;
                    if (b == int'(t_len)) break;
                end else begin
                    idle++;
                    if (idle == TIMEOUT) begin
                        abort = 1'b1;
                        break;
                    end
                end
            end
        end
        wstart  = n + 2 + ACC_LAT;
        cc      = n + 1 + ACC_LAT;
        cap_val = step * 64'((cc < cap) ? cc : cap);
        done_k  = abort ? n + 2 : wstart + hold + 1;
        last_k  = (rst_at > 0) ? rst_at + 3 : done_k + 2;
        was_reset = (rst_at > 0) && (rst_at < done_k);
        exp_dc  = was_reset ? 0 : 1;
        exp_hs  = (was_reset || abort) ? 0 : 1;

        @(posedge clk); #1;
        done_count = 0;
        hs_count   = 0;
        start = 1'b1; len = t_len; rd_tvalid = 1'b0; m_axis_tready = 1'b0;
        acc_sum = '0; rst = 1'b0;
        exp_acc_clr = 1'b0; exp_rd_tready = 1'b0; exp_tvalid = 1'b0;
        exp_busy = 1'b0; exp_done = 1'b0; exp_err = m_err;
        exp_tdata = m_tdata; exp_beats = m_beats; exp_cycles = m_cycles;

        for (int k = 1; k <= last_k; k++) begin
            @(posedge clk); #1;
            start         = (start_in_read && k == 3) || (start_in_done && k == done_k);
            len           = start ? 32'd9 : t_len;
            rd_tvalid     = (k >= 2 && k - 2 < 32) ? pat[k-2] : 1'b0;
            m_axis_tready = !abort && (k == wstart + hold);
            acc_sum       = step * 64'((k < cap) ? k : cap);
            rst           = (k == rst_at);
            if (rst_at > 0 && k > rst_at) begin
                m_err = 1'b0; m_tdata = '0; m_beats = '0; m_cycles = '0;
                exp_acc_clr = 1'b0; exp_rd_tready = 1'b0; exp_tvalid = 1'b0;
                exp_busy = 1'b0; exp_done = 1'b0;
            end else begin
                if (k == 1) m_err = 1'b0;
                if (abort && k == done_k) m_err = 1'b1;
                if (!abort && k == wstart) m_tdata = cap_val;
                if (k == done_k + 1) begin
                    m_beats  = LEN_W'(b);
                    m_cycles = LEN_W'(n);
                end
                exp_acc_clr   = (k == 1);
                exp_rd_tready = (k >= 2 && k <= n + 1);
                exp_tvalid    = !abort && k >= wstart && k < done_k;
                exp_busy      = (k <= done_k);
                exp_done      = (k == done_k);
            end
            exp_err = m_err; exp_tdata = m_tdata;
            exp_beats = m_beats; exp_cycles = m_cycles;
        end
        start = 1'b0; rst = 1'b0; rd_tvalid = 1'b0; m_axis_tready = 1'b0;
        checkOutput("done_count", 64'(done_count), 64'(exp_dc));
        checkOutput("result_hs",  64'(hs_count),   64'(exp_hs));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; len = '0; rd_tvalid = 1'b0;
        acc_sum = '0; m_axis_tready = 1'b0;
        m_err = 1'b0; m_tdata = '0; m_beats = '0; m_cycles = '0;
        repeat (2) @(posedge clk);
        #1;
        exp_acc_clr = 1'b0; exp_rd_tready = 1'b0; exp_tvalid = 1'b0;
        exp_busy = 1'b0; exp_done = 1'b0; exp_err = 1'b0;
        exp_tdata = '0; exp_beats = '0; exp_cycles = '0;
        chk_en = 1'b1;
        rst = 1'b0;

        $display("[TB] basic run len=4");
        applyStimulus(32'd4, 32'hFFFF_FFFF, 0, 64'h19, 4, 1'b0, 1'b0, 0);
        checkOutput("basic_beats",  64'(beats),  64'd4);
        checkOutput("basic_cycles", 64'(cycles), 64'd4);
        checkOutput("basic_tdata",  m_axis_tdata, 64'h64);
        checkOutput("basic_err",    64'(err),    64'd0);

        $display("[TB] back-pressure len=3");
        applyStimulus(32'd3, 32'h0000_0019, 6, 64'h1111, 1000, 1'b0, 1'b0, 0);
        checkOutput("bp_beats",  64'(beats),  64'd3);
        checkOutput("bp_cycles", 64'(cycles), 64'd5);
        checkOutput("bp_tdata",  m_axis_tdata, 64'h8888);

        $display("[TB] timeout len=5 with 2 beats");
        applyStimulus(32'd5, 32'h0000_0003, 0, 64'h7, 1000, 1'b0, 1'b0, 0);
        checkOutput("to_err",    64'(err),    64'd1);
        checkOutput("to_beats",  64'(beats),  64'd2);
        checkOutput("to_cycles", 64'(cycles), 64'd10);
        checkOutput("to_tdata",  m_axis_tdata, 64'h8888);

        $display("[TB] zero length");
        applyStimulus(32'd0, 32'hFFFF_FFFF, 0, 64'h0, 0, 1'b0, 1'b0, 0);
        checkOutput("zl_err",    64'(err),    64'd0);
        checkOutput("zl_beats",  64'(beats),  64'd0);
        checkOutput("zl_cycles", 64'(cycles), 64'd0);
        checkOutput("zl_tdata",  m_axis_tdata, 64'h0);

        $display("[TB] start while busy");
        applyStimulus(32'd3, 32'hFFFF_FFFF, 1, 64'h5, 1000, 1'b1, 1'b1, 0);
        checkOutput("busy_beats", 64'(beats),  64'd3);
        checkOutput("busy_tdata", m_axis_tdata, 64'h1E);

        $display("[TB] mid-test reset");
        applyStimulus(32'd8, 32'h0000_0003, 0, 64'h9, 1000, 1'b0, 1'b0, 4);
        checkOutput("rst_beats", 64'(beats),  64'd0);
        checkOutput("rst_tdata", m_axis_tdata, 64'h0);

        $display("[TB] fresh run after reset len=2");
        applyStimulus(32'd2, 32'hFFFF_FFFF, 2, 64'h3, 1000, 1'b0, 1'b0, 0);
        checkOutput("fresh_beats",  64'(beats),  64'd2);
        checkOutput("fresh_cycles", 64'(cycles), 64'd2);
        checkOutput("fresh_tdata",  m_axis_tdata, 64'hF);

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
